// File: rtl/rv32i_mem_pkg.sv
// Shared types and lane helpers for the RV32I data-memory responder.
// Lane offsets are byte offsets within a little-endian 32-bit word.
package rv32i_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_RESP
  } mem_state_e;

  localparam logic [2:0] MEM_B  = 3'd0;
  localparam logic [2:0] MEM_H  = 3'd1;
  localparam logic [2:0] MEM_W  = 3'd2;
  localparam logic [2:0] MEM_BU = 3'd4;
  localparam logic [2:0] MEM_HU = 3'd5;

  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [2:0]  size,
                                               input logic [1:0]  off);
    logic [31:0] res;
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {off, 3'b000});
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      MEM_B:   res = {{24{b[7]}}, b};
      MEM_BU:  res = {24'h0, b};
      MEM_H:   res = {{16{h[15]}}, h};
      MEM_HU:  res = {16'h0, h};
      MEM_W:   res = word;
      default: res = 32'h0;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                             input logic [31:0] wdata,
                                             input logic [2:0]  size,
                                             input logic [1:0]  off);
    logic [31:0] mask;
    logic [31:0] ins;
    case (size)
      MEM_B: begin
        mask = 32'h0000_00FF << {off, 3'b000};
        ins  = {24'h0, wdata[7:0]} << {off, 3'b000};
      end
      MEM_H: begin
        mask = 32'h0000_FFFF << {off[1], 4'b0000};
        ins  = {16'h0, wdata[15:0]} << {off[1], 4'b0000};
      end
      default: begin
        mask = 32'hFFFF_FFFF;
        ins  = wdata;
      end
    endcase
    return (word & ~mask) | (ins & mask);
  endfunction

endpackage

// File: rtl/mem_word_array.sv
// Single-port word RAM: registered read, whole-word write, no reset.
module mem_word_array #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  localparam int IDX_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder: one request at a time, sub-word stores done as
// read-modify-write against a single-port word array.
module data_mem_responder
  import rv32i_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_size,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  localparam int          IDX_W      = $clog2(DEPTH);
  localparam logic [31:0] BYTE_LIMIT = 32'(DEPTH * 4);

  mem_state_e            state_q, state_d;
  logic                  we_q, we_d;
  logic [2:0]            size_q, size_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [1:0]            off_q, off_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  err_q, err_d;

  logic                  acc_err;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic [DATA_WIDTH-1:0] wr_word;

  always_comb begin
    case (req_size)
      MEM_B, MEM_BU: acc_err = 1'b0;
      MEM_H, MEM_HU: acc_err = req_addr[0];
      MEM_W:         acc_err = (req_addr[1:0] != 2'b00);
      default:       acc_err = 1'b1;
    endcase
    if (req_we && (req_size == MEM_BU || req_size == MEM_HU)) begin
      acc_err = 1'b1;
    end
    if (32'(req_addr) >= BYTE_LIMIT) begin
      acc_err = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    idx_d   = idx_q;
    off_d   = off_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          idx_d   = req_addr[IDX_W+1:2];
          off_d   = req_addr[1:0];
          wdata_d = req_wdata;
          err_d   = acc_err;
          if (acc_err) begin
            state_d = ST_RESP;
          end else if (req_we && req_size == MEM_W) begin
            state_d = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_RD:   state_d = we_q ? ST_WR : ST_RESP;
      ST_WR:   state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      size_q  <= 3'd0;
      idx_q   <= '0;
      off_q   <= 2'd0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  // The word read in RD is held in the array's output register through WR/RESP.
  assign wr_word = (size_q == MEM_W) ? wdata_q
                                     : lane_merge(ram_rdata, wdata_q, size_q, off_q);

  mem_word_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_array (
    .clk    (clk),
    .we_i   (state_q == ST_WR),
    .addr_i (idx_q),
    .wdata_i(wr_word),
    .rdata_o(ram_rdata)
  );

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_rdata = (rsp_valid && !err_q && !we_q)
                     ? lane_extract(ram_rdata, size_q, off_q) : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: loads, stores, RMW, errors, reset
// during a write and back-to-back throughput.
module tb_data_mem_responder;

  localparam int AW    = 12;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [2:0]    req_size = 3'd0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  data_mem_responder #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(AW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_size (req_size),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One request; returns response data/err, latency in cycles and the
  // number of cycles req_ready was low up to and including the response.
  task automatic xact(input logic we, input logic [2:0] size, input logic [AW-1:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rdata,
                      output logic err, output int lat, output int rlow);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!req_ready && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    req_valid = 1'b1;
    req_we    = we;
    req_size  = size;
    req_addr  = addr;
    req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    lat   = 1;
    rlow  = 0;
    rdata = 32'hx;
    err   = 1'bx;
    forever begin
      if (!req_ready) rlow++;
      if (rsp_valid) begin
        rdata = rsp_rdata;
        err   = rsp_err;
        break;
      end
      if (lat >= 10) begin
        check("rsp_timeout", 32'(lat), 32'd0);
        break;
      end
      @(negedge clk);
      lat++;
    end
    $display("xact we=%0d size=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
             we, size, addr, wdata, rdata, err, lat);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat, rlow;

  task automatic load_chk(input string tag, input logic [2:0] size, input logic [AW-1:0] addr,
                          input logic [31:0] exp);
    xact(1'b0, size, addr, 32'h0, rd, er, lat, rlow);
    check({tag, "_data"}, rd, exp);
    check({tag, "_err"}, 32'(er), 32'd0);
  endtask

  task automatic err_chk(input string tag, input logic we, input logic [2:0] size,
                         input logic [AW-1:0] addr);
    xact(we, size, addr, 32'hCAFE_F00D, rd, er, lat, rlow);
    check({tag, "_err"}, 32'(er), 32'd1);
    check({tag, "_lat"}, 32'(lat), 32'd1);
    check({tag, "_data"}, rd, 32'd0);
  endtask

  int seen;
  int acc_cyc[8];
  int rsp_cyc[8];
  int n_acc, n_rsp;

  initial begin
    repeat (2) @(negedge clk);
    check("reset_ready", 32'(req_ready), 32'd1);
    check("reset_valid", 32'(rsp_valid), 32'd0);
    check("reset_rdata", rsp_rdata, 32'd0);
    check("reset_err", 32'(rsp_err), 32'd0);
    rst = 1'b0;

    // Store then load
    xact(1'b1, 3'd2, 12'h010, 32'hDEAD_BEEF, rd, er, lat, rlow);
    check("sw_err", 32'(er), 32'd0);
    check("sw_lat", 32'(lat), 32'd2);
    check("sw_rdata", rd, 32'd0);
    xact(1'b0, 3'd2, 12'h010, 32'h0, rd, er, lat, rlow);
    check("lw_data", rd, 32'hDEAD_BEEF);
    check("lw_lat", 32'(lat), 32'd2);

    // Lane extraction
    load_chk("lb11", 3'd0, 12'h011, 32'hFFFF_FFBE);
    load_chk("lbu11", 3'd4, 12'h011, 32'h0000_00BE);
    load_chk("lh12", 3'd1, 12'h012, 32'hFFFF_DEAD);
    load_chk("lhu12", 3'd5, 12'h012, 32'h0000_DEAD);
    load_chk("lbu10", 3'd4, 12'h010, 32'h0000_00EF);

    // Sub-word RMW
    xact(1'b1, 3'd0, 12'h013, 32'hAAAA_AA55, rd, er, lat, rlow);
    check("sb_lat", 32'(lat), 32'd3);
    check("sb_ready_low", 32'(rlow), 32'd3);
    check("sb_err", 32'(er), 32'd0);
    load_chk("lw_after_sb", 3'd2, 12'h010, 32'h55AD_BEEF);
    xact(1'b1, 3'd1, 12'h010, 32'h0000_1234, rd, er, lat, rlow);
    check("sh_lat", 32'(lat), 32'd3);
    load_chk("lw_after_sh", 3'd2, 12'h010, 32'h55AD_1234);

    // Errors
    err_chk("lw_mis", 1'b0, 3'd2, 12'h012);
    err_chk("sh_mis", 1'b1, 3'd1, 12'h001);
    err_chk("lw_oor", 1'b0, 3'd2, 12'(DEPTH * 4));
    err_chk("size3", 1'b0, 3'd3, 12'h010);
    err_chk("st_bu", 1'b1, 3'd4, 12'h010);
    err_chk("sw_mis", 1'b1, 3'd2, 12'h011);
    load_chk("lw_after_err", 3'd2, 12'h010, 32'h55AD_1234);

    // Top word is legal
    xact(1'b1, 3'd2, 12'(DEPTH * 4 - 4), 32'h0BAD_F00D, rd, er, lat, rlow);
    check("sw_top_err", 32'(er), 32'd0);
    load_chk("lw_top", 3'd2, 12'(DEPTH * 4 - 4), 32'h0BAD_F00D);

    // Reset during WR of a word store
    xact(1'b1, 3'd2, 12'h020, 32'h0, rd, er, lat, rlow);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 3'd2;
    req_addr  = 12'h020;
    req_wdata = 32'h1234_5678;
    @(negedge clk);
    rst = 1'b1;
    req_valid = 1'b0;
    #1;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("rst_no_rsp", 32'(seen), 32'd0);
    load_chk("lw_after_rst", 3'd2, 12'h020, 32'h0);

    // Back-to-back loads, req_valid held high
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_size  = 3'd2;
    req_addr  = 12'h010;
    n_acc = 0;
    n_rsp = 0;
    for (int i = 0; i < 12; i++) begin
      if (req_ready && n_acc < 8) begin
        acc_cyc[n_acc] = i;
        n_acc++;
      end
      if (rsp_valid && n_rsp < 8) begin
        rsp_cyc[n_rsp] = i;
        n_rsp++;
        check("b2b_data", rsp_rdata, 32'h55AD_1234);
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("b2b_rsp_count", 32'(n_rsp), 32'd4);
    check("b2b_acc_count", 32'(n_acc), 32'd4);
    for (int k = 1; k < n_rsp && k < n_acc; k++) begin
      check("b2b_rsp_gap", 32'(rsp_cyc[k] - rsp_cyc[k-1]), 32'd3);
      check("b2b_acc_after_rsp", 32'(acc_cyc[k]), 32'(rsp_cyc[k-1] + 1));
    end
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
